// File: rtl/reservation_station_ooo_pkg.sv
// Shared types and defaults for the out-of-order reservation station.
// The entry struct documents the per-slot layout at the default widths.
package reservation_station_ooo_pkg;

  localparam int DEF_NUM_ENTRIES = 8;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_TAG_W       = 6;
  localparam int DEF_OP_W        = 4;
  localparam int PC_W            = 32;

  localparam int ISSUE_OLDEST = 1;
  localparam int ISSUE_LOWEST = 0;

  typedef struct packed {
    logic                  valid;
    logic [DEF_OP_W-1:0]   op;
    logic [DEF_TAG_W-1:0]  dest_tag;
    logic [PC_W-1:0]       pc;
    logic                  a_rdy;
    logic [DEF_TAG_W-1:0]  a_tag;
    logic [DEF_DATA_W-1:0] a_data;
    logic                  b_rdy;
    logic [DEF_TAG_W-1:0]  b_tag;
    logic [DEF_DATA_W-1:0] b_data;
  } rs_entry_t;

endpackage

// File: rtl/reservation_station_ooo_if.sv
// Dispatch, CDB and issue bundles of the reservation station.
// master = surrounding pipeline, slave = the station itself.
interface reservation_station_ooo_if
  import reservation_station_ooo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int OP_W   = DEF_OP_W
);
  logic              disp_valid;
  logic              disp_ready;
  logic [OP_W-1:0]   disp_op;
  logic [TAG_W-1:0]  disp_dest_tag;
  logic [PC_W-1:0]   disp_pc;
  logic              disp_a_rdy;
  logic [TAG_W-1:0]  disp_a_tag;
  logic [DATA_W-1:0] disp_a_data;
  logic              disp_b_rdy;
  logic [TAG_W-1:0]  disp_b_tag;
  logic [DATA_W-1:0] disp_b_data;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;

  logic              iss_valid;
  logic              iss_ready;
  logic [OP_W-1:0]   iss_op;
  logic [TAG_W-1:0]  iss_dest_tag;
  logic [PC_W-1:0]   iss_pc;
  logic [DATA_W-1:0] iss_a;
  logic [DATA_W-1:0] iss_b;

  modport master (
    output disp_valid, disp_op, disp_dest_tag, disp_pc,
           disp_a_rdy, disp_a_tag, disp_a_data,
           disp_b_rdy, disp_b_tag, disp_b_data,
           cdb_valid, cdb_tag, cdb_data, iss_ready,
    input  disp_ready, iss_valid, iss_op, iss_dest_tag, iss_pc, iss_a, iss_b
  );

  modport slave (
    input  disp_valid, disp_op, disp_dest_tag, disp_pc,
           disp_a_rdy, disp_a_tag, disp_a_data,
           disp_b_rdy, disp_b_tag, disp_b_data,
           cdb_valid, cdb_tag, cdb_data, iss_ready,
    output disp_ready, iss_valid, iss_op, iss_dest_tag, iss_pc, iss_a, iss_b
  );

endinterface

// File: rtl/reservation_station_ooo_age_picker.sv
// One-hot issue grant from the eligible mask: oldest eligible entry via an
// age matrix, or simply the lowest eligible index.
module reservation_station_ooo_age_picker
  import reservation_station_ooo_pkg::*;
#(
  parameter int NUM_ENTRIES  = DEF_NUM_ENTRIES,
  parameter int OLDEST_FIRST = ISSUE_OLDEST
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_flush,
  input  logic [NUM_ENTRIES-1:0] i_valid,
  input  logic [NUM_ENTRIES-1:0] i_alloc,
  input  logic [NUM_ENTRIES-1:0] i_free,
  input  logic [NUM_ENTRIES-1:0] i_elig,
  output logic [NUM_ENTRIES-1:0] o_grant
);

  generate
    if (OLDEST_FIRST == ISSUE_OLDEST) begin : g_age
      // r_older[i][j] set means entry j was dispatched before entry i
      logic [NUM_ENTRIES-1:0] r_older [NUM_ENTRIES];

      always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
          for (int i = 0; i < NUM_ENTRIES; i++) r_older[i] <= '0;
        end else if (i_flush) begin
          for (int i = 0; i < NUM_ENTRIES; i++) r_older[i] <= '0;
        end else begin
          for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (i_alloc[i]) r_older[i] <= i_valid & ~i_free;
            else            r_older[i] <= r_older[i] & ~i_free;
          end
        end
      end

      always_comb begin
        o_grant = '0;
        for (int i = 0; i < NUM_ENTRIES; i++)
          o_grant[i] = i_elig[i] && ((r_older[i] & i_elig) == '0);
      end
    end else begin : g_lowest
      logic w_found;

      always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
          if (i_elig[i] && !w_found) begin
            o_grant[i] = 1'b1;
            w_found    = 1'b1;
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/reservation_station_ooo.sv
// Reservation station: buffers dispatched ops, wakes operands from the CDB,
// and issues one operand-complete op per cycle to a single functional unit.
module reservation_station_ooo
  import reservation_station_ooo_pkg::*;
#(
  parameter int NUM_ENTRIES  = DEF_NUM_ENTRIES,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int TAG_W        = DEF_TAG_W,
  parameter int OP_W         = DEF_OP_W,
  parameter int OLDEST_FIRST = ISSUE_OLDEST
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_flush,
  reservation_station_ooo_if.slave     rs_if,
  output logic [$clog2(NUM_ENTRIES):0] o_occupancy
);

  localparam int OCC_W = $clog2(NUM_ENTRIES) + 1;

  logic [NUM_ENTRIES-1:0] r_valid, r_a_rdy, r_b_rdy;
  logic [OP_W-1:0]        r_op     [NUM_ENTRIES];
  logic [TAG_W-1:0]       r_dest   [NUM_ENTRIES];
  logic [PC_W-1:0]        r_pc     [NUM_ENTRIES];
  logic [TAG_W-1:0]       r_a_tag  [NUM_ENTRIES];
  logic [TAG_W-1:0]       r_b_tag  [NUM_ENTRIES];
  logic [DATA_W-1:0]      r_a_data [NUM_ENTRIES];
  logic [DATA_W-1:0]      r_b_data [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0] w_alloc, w_alloc_fire, w_free, w_elig, w_grant;
  logic [NUM_ENTRIES-1:0] w_a_wake, w_b_wake;
  logic                   w_alloc_found, w_disp_ready, w_disp_fire;
  logic                   w_disp_a_hit, w_disp_b_hit, w_cdb_live;
  logic                   w_iss_valid, w_iss_fire;
  logic [OCC_W-1:0]       w_occ;
  logic [OP_W-1:0]        w_iss_op;
  logic [TAG_W-1:0]       w_iss_dest;
  logic [PC_W-1:0]        w_iss_pc;
  logic [DATA_W-1:0]      w_iss_a, w_iss_b;

  always_comb begin
    w_alloc       = '0;
    w_alloc_found = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!r_valid[i] && !w_alloc_found) begin
        w_alloc[i]    = 1'b1;
        w_alloc_found = 1'b1;
      end
    end
  end

  assign w_disp_ready = ~&r_valid;
  assign w_disp_fire  = rs_if.disp_valid && w_disp_ready && !i_flush;
  assign w_alloc_fire = w_disp_fire ? w_alloc : '0;
  assign w_cdb_live   = rs_if.cdb_valid && !i_flush;
  assign w_disp_a_hit = rs_if.cdb_valid && (rs_if.cdb_tag == rs_if.disp_a_tag);
  assign w_disp_b_hit = rs_if.cdb_valid && (rs_if.cdb_tag == rs_if.disp_b_tag);

  always_comb begin
    w_a_wake = '0;
    w_b_wake = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_a_wake[i] = w_cdb_live && r_valid[i] && !r_a_rdy[i] && (r_a_tag[i] == rs_if.cdb_tag);
      w_b_wake[i] = w_cdb_live && r_valid[i] && !r_b_rdy[i] && (r_b_tag[i] == rs_if.cdb_tag);
    end
  end

  // Eligibility comes from registered ready bits only, so a wakeup issues a cycle later
  assign w_elig      = r_valid & r_a_rdy & r_b_rdy;
  assign w_iss_valid = (|w_elig) && !i_flush;
  assign w_iss_fire  = w_iss_valid && rs_if.iss_ready;
  assign w_free      = w_iss_fire ? w_grant : '0;

  reservation_station_ooo_age_picker #(
    .NUM_ENTRIES  (NUM_ENTRIES),
    .OLDEST_FIRST (OLDEST_FIRST)
  ) u_picker (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_flush (i_flush),
    .i_valid (r_valid),
    .i_alloc (w_alloc_fire),
    .i_free  (w_free),
    .i_elig  (w_elig),
    .o_grant (w_grant)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_valid <= '0;
      r_a_rdy <= '0;
      r_b_rdy <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (w_alloc_fire[i]) begin
          r_valid[i] <= 1'b1;
          r_a_rdy[i] <= rs_if.disp_a_rdy || w_disp_a_hit;
          r_b_rdy[i] <= rs_if.disp_b_rdy || w_disp_b_hit;
        end else begin
          if (w_free[i])   r_valid[i] <= 1'b0;
          if (w_a_wake[i]) r_a_rdy[i] <= 1'b1;
          if (w_b_wake[i]) r_b_rdy[i] <= 1'b1;
        end
      end
    end
  end

  // Payload storage carries no reset; it is only observed through valid entries
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (w_alloc_fire[i]) begin
        r_op[i]     <= rs_if.disp_op;
        r_dest[i]   <= rs_if.disp_dest_tag;
        r_pc[i]     <= rs_if.disp_pc;
        r_a_tag[i]  <= rs_if.disp_a_tag;
        r_b_tag[i]  <= rs_if.disp_b_tag;
        r_a_data[i] <= rs_if.disp_a_rdy ? rs_if.disp_a_data : rs_if.cdb_data;
        r_b_data[i] <= rs_if.disp_b_rdy ? rs_if.disp_b_data : rs_if.cdb_data;
      end else begin
        if (w_a_wake[i]) r_a_data[i] <= rs_if.cdb_data;
        if (w_b_wake[i]) r_b_data[i] <= rs_if.cdb_data;
      end
    end
  end

  always_comb begin
    w_iss_op   = '0;
    w_iss_dest = '0;
    w_iss_pc   = '0;
    w_iss_a    = '0;
    w_iss_b    = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (w_iss_valid && w_grant[i]) begin
        w_iss_op   = r_op[i];
        w_iss_dest = r_dest[i];
        w_iss_pc   = r_pc[i];
        w_iss_a    = r_a_data[i];
        w_iss_b    = r_b_data[i];
      end
    end
  end

  always_comb begin
    w_occ = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) w_occ = w_occ + OCC_W'(r_valid[i]);
  end

  assign rs_if.disp_ready   = w_disp_ready;
  assign rs_if.iss_valid    = w_iss_valid;
  assign rs_if.iss_op       = w_iss_op;
  assign rs_if.iss_dest_tag = w_iss_dest;
  assign rs_if.iss_pc       = w_iss_pc;
  assign rs_if.iss_a        = w_iss_a;
  assign rs_if.iss_b        = w_iss_b;
  assign o_occupancy        = w_occ;

endmodule
